// File: rtl/layer_mem_reader.sv
// layer_mem_reader: reads layer 0 (64x64) or layer 1 (32x32) of the layer memory
// in raster order and streams the pixels out over valid/ready through a small FIFO.
// Read issue is throttled so outstanding reads never exceed the free FIFO space,
// so backpressure stalls the memory side without losing or duplicating pixels.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | waiting for start; crd low, csel low
//  S_READ  | issuing reads (address = pixel index) while FIFO space allows
//  S_DRAIN | all reads issued; emptying the FIFO until the last beat
module layer_mem_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        layer_sel,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [12:0] cdata_rd,
    output logic        csel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // The capture path assumes data returns in the cycle crd is high.
    generate
        if (MEM_LAT != 1) begin : g_bad_lat
            $error("layer_mem_reader: only MEM_LAT == 1 is supported");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("layer_mem_reader: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_layer;
    logic [12:0]     r_rd_cnt;
    logic [12:0]     r_pop_cnt;
    logic            r_crd;
    logic [11:0]     r_caddr;

    // FIFO entry: {sof, eol, eof, data[12:0]}
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [12:0]     w_n;
    logic [12:0]     w_last;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;
    logic            w_issue;
    logic            w_sof;
    logic            w_eol;
    logic            w_eof;
    logic            w_last_beat;
    logic            w_start_ok;
    logic [15:0]     w_head;

    // Frame geometry, FIFO bookkeeping and read-issue throttle.
    always_comb begin
        w_n         = r_layer ? 13'd1024 : 13'd4096;
        w_last      = w_n - 13'd1;
        w_push      = r_crd;
        w_pop       = (r_count != '0) && out_ready;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        // Space check uses next-cycle occupancy so a read issued now always has a slot.
        w_issue     = (r_state == S_READ) && (r_rd_cnt != w_n) &&
                      (w_count_nxt < CW'(FIFO_DEPTH));
        w_sof       = (r_caddr == 12'd0);
        w_eol       = r_layer ? (&r_caddr[4:0]) : (&r_caddr[5:0]);
        w_eof       = ({1'b0, r_caddr} == w_last);
        w_last_beat = w_pop && (r_pop_cnt == w_last);
        w_start_ok  = (r_state == S_IDLE) && start;
        w_head      = r_mem[r_rptr];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)             w_state_nxt = S_READ;
            S_READ:  if (r_rd_cnt == w_n)   w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_beat)       w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (r_state == S_READ) || (r_state == S_DRAIN);
        done = (r_state == S_DRAIN) && w_last_beat;
    end

    // Frame control: layer latch, read address generation and beat counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_layer   <= 1'b0;
            r_rd_cnt  <= '0;
            r_pop_cnt <= '0;
            r_crd     <= 1'b0;
            r_caddr   <= '0;
        end else begin
            r_crd <= w_issue;
            if (w_start_ok) begin
                r_layer   <= layer_sel;
                r_rd_cnt  <= '0;
                r_pop_cnt <= '0;
            end else begin
                if (w_issue) begin
                    r_caddr  <= r_rd_cnt[11:0];
                    r_rd_cnt <= r_rd_cnt + 13'd1;
                end
                if (w_pop) begin
                    r_pop_cnt <= r_pop_cnt + 13'd1;
                end
                if ((r_state == S_DRAIN) && w_last_beat) begin
                    r_layer <= 1'b0;
                end
            end
        end
    end

    // Output FIFO: captures read data tagged with the frame position of its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {w_sof, w_eol, w_eof, cdata_rd};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Stream and memory-port outputs; flags only asserted alongside a valid beat.
    always_comb begin
        crd       = r_crd;
        caddr_rd  = r_caddr;
        csel      = r_layer;
        out_valid = (r_count != '0);
        out_data  = w_head[12:0];
        out_sof   = out_valid && w_head[15];
        out_eol   = out_valid && w_head[14];
        out_eof   = out_valid && w_head[13];
    end

endmodule

// File: tb/tb_layer_mem_reader.sv
// Directed bench for layer_mem_reader: a table of frame scenarios checked beat by
// beat against a reference pixel model, plus hand sequences for reset behaviour.
module tb_layer_mem_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        layer_sel = 1'b0;
    logic        busy, done, crd, csel;
    logic [11:0] caddr_rd;
    logic [12:0] cdata_rd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_data;
    logic        out_sof, out_eol, out_eof;

    int dmode = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic layer;
        int   dmode;      // 0: data = address, 1: scrambled data
        int   rmode;      // 0: ready high, 1: random ready, 2: ready low for 12 cycles
        bit   start_mid;  // pulse start around beat 500
        int   n;          // expected beats
        int   w;          // expected row width
    } frame_t;

    frame_t tbl[7];

    layer_mem_reader #(.FIFO_DEPTH(4), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .layer_sel(layer_sel),
        .busy(busy), .done(done), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd), .csel(csel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mem_f(input logic [11:0] a, input int m);
        if (m == 0) return {1'b0, a};
        return 13'((int'(a) * 37 + 5) & 32'h1fff);
    endfunction

    // Memory returns data for the presented address in the crd cycle.
    always_comb cdata_rd = mem_f(caddr_rd, dmode);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, crd, csel, out_valid, out_sof, out_eol, out_eof,
                    caddr_rd, out_data});
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the frame.
    task automatic run_frame(input frame_t f);
        int          idx;
        int          it;
        int          reads;
        logic [11:0] exp_addr;
        bit          stalled;
        logic [16:0] prev;
        idx = 0; it = 0; reads = 0; exp_addr = '0; stalled = 0; prev = '0;
        layer_sel = f.layer;
        dmode     = f.dmode;
        out_ready = (f.rmode != 2);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        layer_sel = ~f.layer;
        while (idx < f.n && it < 4 * f.n + 100) begin
            case (f.rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (it >= 12);
            endcase
            start = f.start_mid && (idx == 500);
            @(negedge clk);
            if (it == 0) chk("lat_idle_cycle", {busy, crd, out_valid}, 3'b100);
            if (it == 1) chk("lat_first_read", {crd, out_valid, csel, caddr_rd}, {1'b1, 1'b0, f.layer, 12'd0});
            if (it == 2) chk("lat_first_valid", out_valid, 1'b1);
            if (f.rmode == 2 && it == 11) chk("stall_reads", {reads, crd}, {32'd4, 1'b0});
            if (crd) begin
                chk("read_addr", caddr_rd, exp_addr);
                exp_addr++;
                reads++;
            end
            if (stalled) chk("stall_hold", {out_valid, out_data, out_sof, out_eol, out_eof}, prev);
            if (out_valid && out_ready) begin
                chk("beat_data", out_data, mem_f(12'(idx), f.dmode));
                chk("beat_flags", {out_sof, out_eol, out_eof, done},
                    {idx == 0, (idx % f.w) == f.w - 1, idx == f.n - 1, idx == f.n - 1});
                idx++;
            end else begin
                chk("done_quiet", done, 1'b0);
            end
            stalled = out_valid && !out_ready;
            prev    = {out_valid, out_data, out_sof, out_eol, out_eof};
            it++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("frame_beats", idx, f.n);
        chk("frame_reads", reads, f.n);
        if (f.rmode == 0) chk("frame_cycles", it, f.n + 2);
        chk("idle_after_done", {busy, csel, crd, out_valid}, 4'b0000);
    endtask

    initial begin
        int idx;
        tbl[0] = '{1'b1, 0, 0, 1'b0, 1024, 32};
        tbl[1] = '{1'b0, 0, 0, 1'b0, 4096, 64};
        tbl[2] = '{1'b1, 1, 2, 1'b0, 1024, 32};
        tbl[3] = '{1'b1, 1, 1, 1'b0, 1024, 32};
        tbl[4] = '{1'b1, 0, 0, 1'b1, 1024, 32};
        tbl[5] = '{1'b1, 1, 0, 1'b0, 1024, 32};
        tbl[6] = '{1'b0, 1, 1, 1'b0, 4096, 64};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", all_outs(), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i]);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of a frame, then a clean restart.
        idx       = 0;
        layer_sel = 1'b1;
        dmode     = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) idx++;
            if (idx == 300) break;
            @(posedge clk); #1;
        end
        chk("midframe_beats", idx, 300);
        chk("midframe_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midframe_reset_outputs", all_outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_outputs", all_outs(), 64'd0);
        run_frame(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
